// File: rtl/wb_bridge_pkg.sv
// rtl/wb_bridge_pkg.sv - shared state type and constants for wb_mem_bridge
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
  localparam logic [31:0] WB_ERR_RDATA = 32'h0000_0000;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - 8-bit stall counter, expired on the LIMIT-th enabled cycle
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/wb_mem_bridge.sv
// rtl/wb_mem_bridge.sv - level memory request to Wishbone B4 classic master bridge
// Optional stall timeout enabled by defining WB_TIMEOUT_EN.
module wb_mem_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_lock,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic        wb_lock_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  state_t      state_q, state_d;
  logic        cyc_d, stb_d, we_d, lock_d, ack_d, err_d;
  logic [31:0] adr_d, dat_d, rdata_d;
  logic [3:0]  sel_d;
  logic        timeout;

`ifdef WB_TIMEOUT_EN
  logic tmo_enable, tmo_clear;

  assign tmo_enable = (state_q == ST_ACTIVE) && !wb_ack_i && !wb_err_i;
  assign tmo_clear  = (state_q != ST_ACTIVE);

  wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (tmo_enable),
    .clear  (tmo_clear),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_lock_o <= 1'b0;
      wb_adr_o  <= 32'h0;
      wb_dat_o  <= 32'h0;
      wb_sel_o  <= 4'h0;
      mem_rdata <= 32'h0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= stb_d;
      wb_we_o   <= we_d;
      wb_lock_o <= lock_d;
      wb_adr_o  <= adr_d;
      wb_dat_o  <= dat_d;
      wb_sel_o  <= sel_d;
      mem_rdata <= rdata_d;
      mem_ack   <= ack_d;
      mem_err   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = wb_cyc_o;
    stb_d   = wb_stb_o;
    we_d    = wb_we_o;
    lock_d  = wb_lock_o;
    adr_d   = wb_adr_o;
    dat_d   = wb_dat_o;
    sel_d   = wb_sel_o;
    rdata_d = mem_rdata;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          state_d = ST_ACTIVE;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = mem_write;
          lock_d  = mem_lock;
          adr_d   = word_addr(mem_addr);
          dat_d   = mem_wdata;
          sel_d   = WB_SEL_ALL;
        end else begin
          cyc_d  = wb_cyc_o && mem_lock;
          lock_d = wb_lock_o && mem_lock;
        end
      end
      ST_ACTIVE: begin
        if (timeout || wb_err_i || wb_ack_i) begin
          state_d = ST_RECOVER;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          // A locked sequence keeps the bus; a timeout always releases it.
          cyc_d   = wb_lock_o && mem_lock && !timeout;
          lock_d  = wb_lock_o && mem_lock && !timeout;
          if (timeout || wb_err_i) begin
            err_d   = 1'b1;
            rdata_d = WB_ERR_RDATA;
          end else if (!wb_we_o) begin
            rdata_d = wb_dat_i;
          end
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
        cyc_d   = wb_cyc_o && mem_lock;
        lock_d  = wb_lock_o && mem_lock;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_bridge.sv
// tb/tb_wb_mem_bridge.sv - self-checking bench for wb_mem_bridge
// Transaction scoreboard plus directed scenarios; covers WB_TIMEOUT_EN both ways.
module tb_wb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_lock;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack, mem_err;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  always #5 clk = ~clk;

  wb_mem_bridge #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_lock (mem_lock),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_err  (mem_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_lock_o(wb_lock_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  typedef struct {
    logic        we;
    logic        lock;
    logic        err;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] sdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_rdata = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          stb_rise_cnt = 0;
  int          ack_cnt = 0;
  int          amo_low_cnt = 0;
  int          amo_gap_cnt = 0;
  logic        prev_stb = 1'b0;
  logic        amo_mon = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t        e;
    logic [31:0] exp_rd;
    if (wb_stb_o && !prev_stb) stb_rise_cnt++;
    prev_stb = wb_stb_o;
    if (amo_mon) begin
      if (!wb_cyc_o || !wb_lock_o) amo_low_cnt++;
      if (!wb_stb_o) amo_gap_cnt++;
    end
    if (!wb_cyc_o) chk("stb_lock_need_cyc", {30'd0, wb_stb_o, wb_lock_o}, 32'd0);
    if (wb_stb_o) begin
      if (exp_q.size() == 0) begin
        chk("stb_expected", 32'd0, 32'd1);
      end else begin
        e = exp_q[0];
        chk("cyc_with_stb", {31'd0, wb_cyc_o}, 32'd1);
        chk("adr", wb_adr_o, e.adr);
        chk("we", {31'd0, wb_we_o}, {31'd0, e.we});
        chk("sel", {28'd0, wb_sel_o}, 32'h0000_000F);
        chk("lock", {31'd0, wb_lock_o}, {31'd0, e.lock});
        if (e.we) chk("dat", wb_dat_o, e.dat);
      end
    end
    if (mem_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("ack_expected", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        exp_rd = e.err ? 32'h0 : (e.we ? model_rdata : e.sdata);
        chk("rdata_at_ack", mem_rdata, exp_rd);
        chk("err_at_ack", {31'd0, mem_err}, {31'd0, e.err});
        model_rdata = exp_rd;
      end
    end else begin
      chk("err_without_ack", {31'd0, mem_err}, 32'd0);
      chk("rdata_hold", mem_rdata, model_rdata);
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, mem_ack, mem_err}, 32'd0);
    chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
    chk({tag, "_adr"}, wb_adr_o, 32'd0);
    chk({tag, "_dat"}, wb_dat_o, 32'd0);
    chk({tag, "_rdata"}, mem_rdata, 32'd0);
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic lk, input logic err, input logic [31:0] sdata);
    exp_t e;
    e.we = wr; e.lock = lk; e.err = err;
    e.adr = addr & 32'hFFFF_FFFC; e.dat = wdata; e.sdata = sdata;
    exp_q.push_back(e);
  endtask

  // Requester holds the request through the mem_ack cycle, then drops it.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic lk, input int wait_n, input logic s_err, input logic [31:0] sdata,
                         output logic [31:0] got_rdata, output logic got_err,
                         output int rises, output int acks);
    int r0, a0;
    push_exp(wr, addr, wdata, lk, s_err, sdata);
    r0 = stb_rise_cnt;
    a0 = ack_cnt;
    mem_read = !wr; mem_write = wr; mem_addr = addr; mem_wdata = wdata; mem_lock = lk;
    @(negedge clk);
    chk("latch_latency", {31'd0, wb_stb_o}, 32'd1);
    mem_read = wr; mem_write = !wr; mem_addr = ~addr; mem_wdata = ~wdata;
    repeat (wait_n) @(negedge clk);
    wb_ack_i = 1'b1; wb_err_i = s_err; wb_dat_i = sdata;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
    chk("ack_pulse", {31'd0, mem_ack}, 32'd1);
    got_rdata = mem_rdata;
    got_err = mem_err;
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    rises = stb_rise_cnt - r0;
    acks = ack_cnt - a0;
  endtask

  task automatic abort_with_reset();
    int a0;
    #2;
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_lock = 1'b0;
    exp_q.delete();
    model_rdata = 32'h0;
    a0 = ack_cnt;
    @(negedge clk);
    check_zero("abort_rst");
    #2 rst = 1'b0;
    @(negedge clk);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5A5A_5A5A;
    @(negedge clk);
    wb_ack_i = 1'b0;
    @(negedge clk);
    check_zero("late_ack");
    chk("late_ack_count", ack_cnt - a0, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] rd;
    logic        er;
    int          rises, acks, n, a0;
    logic [5:0]  stb_tr, ack_tr, cyc_tr;

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_lock = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    do_xfer(1'b0, 32'h0000_1006, 32'h0, 1'b0, 2, 1'b0, 32'hCAFE_F00D, rd, er, rises, acks);
    chk("read_rdata", rd, 32'hCAFE_F00D);
    chk("read_err", {31'd0, er}, 32'd0);
    chk("read_bus_cycles", rises, 32'd1);
    chk("read_acks", acks, 32'd1);
    chk("read_adr", wb_adr_o, 32'h0000_1004);

    do_xfer(1'b1, 32'h0000_1010, 32'h1234_5678, 1'b0, 0, 1'b0, 32'h0BAD_0BAD, rd, er, rises, acks);
    chk("write_we", {31'd0, wb_we_o}, 32'd1);
    chk("write_dat", wb_dat_o, 32'h1234_5678);
    chk("write_err", {31'd0, er}, 32'd0);
    chk("write_acks", acks, 32'd1);
    chk("write_rdata_prior", rd, 32'hCAFE_F00D);

    do_xfer(1'b0, 32'h0000_1020, 32'h0, 1'b0, 0, 1'b1, 32'h7777_7777, rd, er, rises, acks);
    chk("err_flag", {31'd0, er}, 32'd1);
    chk("err_rdata", rd, 32'h0);
    chk("err_acks", acks, 32'd1);

    // Held request with zero-wait acks: ACTIVE, ack/RECOVER, IDLE, then next ACTIVE.
    push_exp(1'b0, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'h0BB0_0BB0);
    push_exp(1'b0, 32'h0000_4000, 32'h0, 1'b0, 1'b0, 32'h0BB0_0BB0);
    mem_read = 1'b1; mem_addr = 32'h0000_4000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      stb_tr[i] = wb_stb_o; ack_tr[i] = mem_ack; cyc_tr[i] = wb_cyc_o;
      wb_ack_i = wb_stb_o; wb_dat_i = 32'h0BB0_0BB0;
      if (i == 5) mem_read = 1'b0;
    end
    wb_ack_i = 1'b0;
    chk("b2b_stb_trace", {26'd0, stb_tr}, 32'b001001);
    chk("b2b_ack_trace", {26'd0, ack_tr}, 32'b010010);
    chk("b2b_cyc_trace", {26'd0, cyc_tr}, 32'b001001);
    chk("b2b_rdata", mem_rdata, 32'h0BB0_0BB0);

    #1 amo_mon = 1'b1;
    do_xfer(1'b0, 32'h0000_2000, 32'h0, 1'b1, 0, 1'b0, 32'h0000_0005, rd, er, rises, acks);
    chk("amo_read_rdata", rd, 32'h0000_0005);
    chk("amo_between_beats", {29'd0, wb_cyc_o, wb_lock_o, wb_stb_o}, 32'b110);
    do_xfer(1'b1, 32'h0000_2000, 32'h0000_0008, 1'b1, 0, 1'b0, 32'h0, rd, er, rises, acks);
    amo_mon = 1'b0;
    chk("amo_write_dat", wb_dat_o, 32'h0000_0008);
    chk("amo_write_rdata", rd, 32'h0000_0005);
    chk("amo_hold_after", {30'd0, wb_cyc_o, wb_lock_o}, 32'b11);
    chk("amo_cyc_low_cycles", amo_low_cnt, 32'd0);
    chk("amo_stb_gap_seen", {31'd0, amo_gap_cnt > 0}, 32'd1);
    mem_lock = 1'b0;
    @(negedge clk);
    chk("amo_release", {30'd0, wb_cyc_o, wb_lock_o}, 32'b00);

`ifdef WB_TIMEOUT_EN
    push_exp(1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b1, 32'h0);
    mem_read = 1'b1; mem_addr = 32'h0000_3000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ack && n < 20);
    chk("timeout_latency", n, 32'd5);
    chk("timeout_flags", {29'd0, mem_ack, mem_err, wb_cyc_o}, 32'b110);
    chk("timeout_rdata", mem_rdata, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    push_exp(1'b0, 32'h0000_3100, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_read = 1'b1; mem_addr = 32'h0000_3100;
    repeat (2) @(negedge clk);
    chk("abort_in_active", {31'd0, wb_stb_o}, 32'd1);
    abort_with_reset();
`else
    push_exp(1'b0, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_read = 1'b1; mem_addr = 32'h0000_3000;
    a0 = ack_cnt;
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!wb_cyc_o) n++;
    end
    chk("no_timeout_cyc_low", n, 32'd0);
    chk("no_timeout_acks", ack_cnt - a0, 32'd0);
    chk("no_timeout_stb", {31'd0, wb_stb_o}, 32'd1);
    abort_with_reset();
`endif

    do_xfer(1'b0, 32'h0000_5004, 32'h0, 1'b0, 1, 1'b0, 32'h0F0F_1234, rd, er, rises, acks);
    chk("after_reset_rdata", rd, 32'h0F0F_1234);
    chk("after_reset_acks", acks, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
